// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master drives the byte stream and receives memory writes; the loader is the slave.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that assembles little-endian words into instruction memory.
// Optional XOR trailer check is enabled by defining CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              gated_clock,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
`ifdef CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [7:0]        MAX_WORDS = 8'(MEM_BYTES / 4);
  localparam logic [ADDR_W-2:0] WC_ONE    = 1;

  state_t            state_q, state_d;
  logic [1:0]        lane_q;
  logic [7:0]        bytes_q [3];
  logic [ADDR_W-2:0] n_q;
  logic [ADDR_W-2:0] word_count_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              in_ready_d;
  logic              accept;
  logic              start_ok;
  logic              hdr_bad;
  logic              data_acc;
  logic              word_end;
  logic              last_word;

  assign accept    = bus.in_valid & in_ready_d;
  assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign hdr_bad   = (bus.in_data == 8'd0) | (bus.in_data > MAX_WORDS);
  assign data_acc  = accept & (state_q == S_DATA);
  assign word_end  = data_acc & (lane_q == 2'd3);
  // word_count lags a write by one cycle, but words are at least four cycles apart
  assign last_word = (word_count_q == (n_q - WC_ONE));

`ifdef CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge gated_clock or posedge reset) begin
    if (reset) begin
      csum_q <= 8'd0;
    end else if (start_ok || (accept && state_q == S_HDR)) begin
      csum_q <= 8'd0;
    end else if (data_acc) begin
      csum_q <= csum_q ^ bus.in_data;
    end
  end
`endif

  always_ff @(posedge gated_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) state_d = hdr_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (word_end && last_word) begin
`ifdef CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = 1'b0;
    busy       = 1'b0;
    core_hold  = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_HDR, S_DATA: begin
        in_ready_d = 1'b1;
        busy       = 1'b1;
        core_hold  = 1'b1;
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        in_ready_d = 1'b1;
        busy       = 1'b1;
        core_hold  = 1'b1;
      end
`endif
      S_DONE:  done = 1'b1;
      S_ERROR: begin
        error     = 1'b1;
        core_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Lanes 0..2 are parked here; lane 3 goes straight into the write word
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    always_ff @(posedge gated_clock or posedge reset) begin
      if (reset) begin
        bytes_q[gi] <= 8'd0;
      end else if (data_acc && lane_q == 2'(gi)) begin
        bytes_q[gi] <= bus.in_data;
      end
    end
  end

  always_ff @(posedge gated_clock or posedge reset) begin
    if (reset) begin
      lane_q       <= 2'd0;
      n_q          <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
    end else begin
      mem_we_q <= 1'b0;
      if (mem_we_q && word_count_q != n_q) begin
        word_count_q <= word_count_q + WC_ONE;
      end
      if (start_ok) begin
        lane_q       <= 2'd0;
        word_count_q <= '0;
      end
      if (accept && state_q == S_HDR && !hdr_bad) begin
        n_q          <= bus.in_data[ADDR_W-2:0];
        lane_q       <= 2'd0;
        word_count_q <= '0;
      end
      if (data_acc) begin
        lane_q <= lane_q + 2'd1;
      end
      if (word_end) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= {word_count_q[ADDR_W-3:0], 2'b00};
        mem_wdata_q <= {bus.in_data, bytes_q[2], bytes_q[1], bytes_q[0]};
      end
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign word_count    = word_count_q;

endmodule
